// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
// ---------------
// Lets two requesters share one asynchronous SRAM port. The CPU is index 0
// and the program loader/debug port is index 1. Only one transaction runs at
// a time. When both requesters ask at once, the grant alternates between them.
// Each transaction runs IDLE -> SETUP -> ACCESS (WAIT_CYCLES cycles) -> DONE.
// The DONE cycle is a strobe turnaround cycle and carries the one-cycle ack.
//
// Ports
//   Clk, Reset                 : rising-edge clock, synchronous active-high reset
//   cpu_req/we/be/addr/wdata   : CPU request; req is held until cpu_ack
//   cpu_ack                    : one-cycle completion pulse for the CPU
//   ldr_req/we/be/addr/wdata   : loader request (same meaning as the CPU fields)
//   ldr_ack                    : one-cycle completion pulse for the loader
//   rdata                      : read data; valid in the ack cycle, then held
//   grant                      : owner of the current/last transaction (0 = CPU)
//   busy                       : high in SETUP, ACCESS and DONE
//   A                          : SRAM address
//   CE_N/OE_N/WE_N/UB_N/LB_N   : SRAM strobes, active low
//   mem_wdata, mem_wdata_oe    : write data and drive enable for the tri-state pad
//   mem_rdata                  : data returned by the SRAM
// All outputs come straight from flops.

module mem_bus_arbiter #(
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [1:0]        cpu_be,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [1:0]        ldr_be,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_ack,
    output logic [DATA_W-1:0] rdata,
    output logic              grant,
    output logic              busy,
    output logic [ADDR_W-1:0] A,
    output logic              CE_N,
    output logic              OE_N,
    output logic              WE_N,
    output logic              UB_N,
    output logic              LB_N,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [DATA_W-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SETUP  = 2'd1,
        S_ACCESS = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // The counter is loaded with WAIT_CYCLES-1, so ACCESS lasts WAIT_CYCLES cycles.
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    state_t              state_q,        state_d;
    logic [3:0]          cnt_q,          cnt_d;
    logic                grant_q,        grant_d;
    logic                last_grant_q,   last_grant_d;
    logic                we_q,           we_d;
    logic [1:0]          be_q,           be_d;
    logic [ADDR_W-1:0]   a_q,            a_d;
    logic [DATA_W-1:0]   mem_wdata_q,    mem_wdata_d;
    logic                mem_wdata_oe_q, mem_wdata_oe_d;
    logic [DATA_W-1:0]   rdata_q,        rdata_d;
    logic                ce_n_q,         ce_n_d;
    logic                oe_n_q,         oe_n_d;
    logic                we_n_q,         we_n_d;
    logic                ub_n_q,         ub_n_d;
    logic                lb_n_q,         lb_n_d;
    logic                cpu_ack_q,      cpu_ack_d;
    logic                ldr_ack_q,      ldr_ack_d;
    logic                busy_q,         busy_d;

    // Winner selection. On a tie the requester that did not win last time gets the grant.
    logic                pick_ldr_s;
    logic                sel_we_s;
    logic [1:0]          sel_be_s;
    logic [ADDR_W-1:0]   sel_addr_s;
    logic [DATA_W-1:0]   sel_wdata_s;

    // Choose the winning requester and multiplex its request fields.
    always_comb begin
        pick_ldr_s  = ldr_req & (~cpu_req | ~last_grant_q);
        if (pick_ldr_s) begin
            sel_we_s    = ldr_we;
            sel_be_s    = ldr_be;
            sel_addr_s  = ldr_addr;
            sel_wdata_s = ldr_wdata;
        end else begin
            sel_we_s    = cpu_we;
            sel_be_s    = cpu_be;
            sel_addr_s  = cpu_addr;
            sel_wdata_s = cpu_wdata;
        end
    end

    // Next-state and next-output logic. Each output is computed for the state being entered.
    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt_q;
        grant_d        = grant_q;
        last_grant_d   = last_grant_q;
        we_d           = we_q;
        be_d           = be_q;
        a_d            = a_q;
        mem_wdata_d    = mem_wdata_q;
        mem_wdata_oe_d = mem_wdata_oe_q;
        rdata_d        = rdata_q;
        ce_n_d         = ce_n_q;
        oe_n_d         = oe_n_q;
        we_n_d         = we_n_q;
        ub_n_d         = ub_n_q;
        lb_n_d         = lb_n_q;
        cpu_ack_d      = 1'b0;
        ldr_ack_d      = 1'b0;
        busy_d         = busy_q;

        case (state_q)
            S_IDLE: begin
                if (cpu_req | ldr_req) begin
                    // Latch the request fields now so later changes cannot disturb the access.
                    state_d        = S_SETUP;
                    grant_d        = pick_ldr_s;
                    last_grant_d   = pick_ldr_s;
                    we_d           = sel_we_s;
                    be_d           = sel_be_s;
                    a_d            = sel_addr_s;
                    mem_wdata_d    = sel_wdata_s;
                    mem_wdata_oe_d = sel_we_s;
                    ce_n_d         = 1'b0;
                    oe_n_d         = sel_we_s;
                    we_n_d         = 1'b1;
                    ub_n_d         = ~sel_be_s[1];
                    lb_n_d         = ~sel_be_s[0];
                    busy_d         = 1'b1;
                end else begin
                    // A keeps the last address. All strobes stay high.
                    mem_wdata_oe_d = 1'b0;
                    ce_n_d         = 1'b1;
                    oe_n_d         = 1'b1;
                    we_n_d         = 1'b1;
                    ub_n_d         = 1'b1;
                    lb_n_d         = 1'b1;
                    busy_d         = 1'b0;
                end
            end

            S_SETUP: begin
                // Entering ACCESS: same strobes as SETUP, and WE_N drops for a write.
                state_d        = S_ACCESS;
                cnt_d          = WAIT_LOAD;
                ce_n_d         = 1'b0;
                oe_n_d         = we_q;
                we_n_d         = ~we_q;
                ub_n_d         = ~be_q[1];
                lb_n_d         = ~be_q[0];
                mem_wdata_oe_d = we_q;
                busy_d         = 1'b1;
            end

            S_ACCESS: begin
                if (cnt_q == 4'd0) begin
                    // Entering DONE: release the strobes. Write data stays driven past the WE_N rise.
                    state_d        = S_DONE;
                    ce_n_d         = 1'b1;
                    oe_n_d         = 1'b1;
                    we_n_d         = 1'b1;
                    ub_n_d         = 1'b1;
                    lb_n_d         = 1'b1;
                    mem_wdata_oe_d = we_q;
                    cpu_ack_d      = ~grant_q;
                    ldr_ack_d      = grant_q;
                    busy_d         = 1'b1;
                    if (we_q) begin
                        rdata_d = rdata_q;
                    end else begin
                        rdata_d = mem_rdata;
                    end
                end else begin
                    cnt_d          = cnt_q - 4'd1;
                    ce_n_d         = 1'b0;
                    oe_n_d         = we_q;
                    we_n_d         = ~we_q;
                    ub_n_d         = ~be_q[1];
                    lb_n_d         = ~be_q[0];
                    mem_wdata_oe_d = we_q;
                    busy_d         = 1'b1;
                end
            end

            S_DONE: begin
                // Back to IDLE. A request still high there starts a new transaction.
                state_d        = S_IDLE;
                mem_wdata_oe_d = 1'b0;
                ce_n_d         = 1'b1;
                oe_n_d         = 1'b1;
                we_n_d         = 1'b1;
                ub_n_d         = 1'b1;
                lb_n_d         = 1'b1;
                busy_d         = 1'b0;
            end

            default: begin
                state_d        = S_IDLE;
                mem_wdata_oe_d = 1'b0;
                ce_n_d         = 1'b1;
                oe_n_d         = 1'b1;
                we_n_d         = 1'b1;
                ub_n_d         = 1'b1;
                lb_n_d         = 1'b1;
                busy_d         = 1'b0;
            end
        endcase
    end

    // State and output registers. Reset aborts any transaction in progress without an ack.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= 4'd0;
            grant_q        <= 1'b0;
            last_grant_q   <= 1'b1;
            we_q           <= 1'b0;
            be_q           <= 2'b00;
            a_q            <= '0;
            mem_wdata_q    <= '0;
            mem_wdata_oe_q <= 1'b0;
            rdata_q        <= '0;
            ce_n_q         <= 1'b1;
            oe_n_q         <= 1'b1;
            we_n_q         <= 1'b1;
            ub_n_q         <= 1'b1;
            lb_n_q         <= 1'b1;
            cpu_ack_q      <= 1'b0;
            ldr_ack_q      <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            grant_q        <= grant_d;
            last_grant_q   <= last_grant_d;
            we_q           <= we_d;
            be_q           <= be_d;
            a_q            <= a_d;
            mem_wdata_q    <= mem_wdata_d;
            mem_wdata_oe_q <= mem_wdata_oe_d;
            rdata_q        <= rdata_d;
            ce_n_q         <= ce_n_d;
            oe_n_q         <= oe_n_d;
            we_n_q         <= we_n_d;
            ub_n_q         <= ub_n_d;
            lb_n_q         <= lb_n_d;
            cpu_ack_q      <= cpu_ack_d;
            ldr_ack_q      <= ldr_ack_d;
            busy_q         <= busy_d;
        end
    end

    assign cpu_ack      = cpu_ack_q;
    assign ldr_ack      = ldr_ack_q;
    assign rdata        = rdata_q;
    assign grant        = grant_q;
    assign busy         = busy_q;
    assign A            = a_q;
    assign CE_N         = ce_n_q;
    assign OE_N         = oe_n_q;
    assign WE_N         = we_n_q;
    assign UB_N         = ub_n_q;
    assign LB_N         = lb_n_q;
    assign mem_wdata    = mem_wdata_q;
    assign mem_wdata_oe = mem_wdata_oe_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed testbench for mem_bus_arbiter. The main instance uses WAIT_CYCLES = 2.
// A second instance shares the same inputs and uses WAIT_CYCLES = 5.
// Cycle k below counts rising edges after the cycle in which the request was presented.

module tb_mem_bus_arbiter;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        cpu_req, cpu_we, ldr_req, ldr_we;
    logic [1:0]  cpu_be, ldr_be;
    logic [19:0] cpu_addr, ldr_addr;
    logic [15:0] cpu_wdata, ldr_wdata, mem_rdata;

    logic        cpu_ack, ldr_ack, grant, busy, CE_N, OE_N, WE_N, UB_N, LB_N, mem_wdata_oe;
    logic [15:0] rdata, mem_wdata;
    logic [19:0] A;

    logic        cpu_ack5, ldr_ack5, grant5, busy5, ce_n5, oe_n5, we_n5, ub_n5, lb_n5, mem_wdata_oe5;
    logic [15:0] rdata5, mem_wdata5;
    logic [19:0] a5;

    int vectors = 0;
    int miscompares = 0;

    always #5 Clk = ~Clk;

    mem_bus_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(2)) dut (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack),
        .rdata(rdata), .grant(grant), .busy(busy), .A(A),
        .CE_N(CE_N), .OE_N(OE_N), .WE_N(WE_N), .UB_N(UB_N), .LB_N(LB_N),
        .mem_wdata(mem_wdata), .mem_wdata_oe(mem_wdata_oe), .mem_rdata(mem_rdata)
    );

    mem_bus_arbiter #(.ADDR_W(20), .DATA_W(16), .WAIT_CYCLES(5)) dut5 (
        .Clk(Clk), .Reset(Reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_be(cpu_be), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ack(cpu_ack5),
        .ldr_req(ldr_req), .ldr_we(ldr_we), .ldr_be(ldr_be), .ldr_addr(ldr_addr),
        .ldr_wdata(ldr_wdata), .ldr_ack(ldr_ack5),
        .rdata(rdata5), .grant(grant5), .busy(busy5), .A(a5),
        .CE_N(ce_n5), .OE_N(oe_n5), .WE_N(we_n5), .UB_N(ub_n5), .LB_N(lb_n5),
        .mem_wdata(mem_wdata5), .mem_wdata_oe(mem_wdata_oe5), .mem_rdata(mem_rdata)
    );

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset   = 1'b1;
        cpu_req = 1'b0;
        ldr_req = 1'b0;
        tick();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        logic [5:0] strobes;
        cpu_we = 1'b0; ldr_we = 1'b0; cpu_be = 2'b11; ldr_be = 2'b11;
        cpu_addr = 20'h0; ldr_addr = 20'h0; cpu_wdata = 16'h0; ldr_wdata = 16'h0;
        mem_rdata = 16'h0;
        Reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
        tick();
        strobes = {CE_N, OE_N, WE_N, UB_N, LB_N, busy};
        vectors++;
        if (strobes !== 6'b111110) begin
            miscompares++;
            $display("FAIL reset_strobes got %b exp %b", strobes, 6'b111110);
        end
        vectors++;
        if ({cpu_ack, ldr_ack, grant, mem_wdata_oe} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_ctrl got %b exp 0000", {cpu_ack, ldr_ack, grant, mem_wdata_oe});
        end
        vectors++;
        if ({A, mem_wdata, rdata} !== 52'h0) begin
            miscompares++;
            $display("FAIL reset_data got A=%h wd=%h rd=%h exp 0", A, mem_wdata, rdata);
        end
        Reset = 1'b0;
        tick();
        vectors++;
        if (busy !== 1'b0 || CE_N !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle got busy=%b CE_N=%b exp 0/1", busy, CE_N);
        end
    endtask

    task automatic test_cpu_read();
        logic e_lo;
        do_reset();
        cpu_addr = 20'h00012; cpu_we = 1'b0; cpu_be = 2'b11; mem_rdata = 16'hBEEF;
        cpu_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            e_lo = (k <= 3) ? 1'b0 : 1'b1;
            vectors++;
            if (CE_N !== e_lo || OE_N !== e_lo) begin
                miscompares++;
                $display("FAIL cpu_read_ce_oe cyc %0d got %b%b exp %b%b", k, CE_N, OE_N, e_lo, e_lo);
            end
            vectors++;
            if (WE_N !== 1'b1 || ldr_ack !== 1'b0 || mem_wdata_oe !== 1'b0) begin
                miscompares++;
                $display("FAIL cpu_read_we cyc %0d got WE_N=%b ldr_ack=%b oe=%b exp 1/0/0", k, WE_N, ldr_ack, mem_wdata_oe);
            end
            vectors++;
            if (cpu_ack !== (k == 4)) begin
                miscompares++;
                $display("FAIL cpu_read_ack cyc %0d got %b exp %b", k, cpu_ack, (k == 4));
            end
            vectors++;
            if (busy !== (k <= 4)) begin
                miscompares++;
                $display("FAIL cpu_read_busy cyc %0d got %b exp %b", k, busy, (k <= 4));
            end
            if (k >= 4) begin
                vectors++;
                if (rdata !== 16'hBEEF || A !== 20'h00012) begin
                    miscompares++;
                    $display("FAIL cpu_read_data cyc %0d got rd=%h A=%h exp BEEF/00012", k, rdata, A);
                end
            end
            if (k == 1) begin
                vectors++;
                if (grant !== 1'b0) begin
                    miscompares++;
                    $display("FAIL cpu_read_grant got %b exp 0", grant);
                end
            end
            if (k == 4) begin
                cpu_req = 1'b0;
                mem_rdata = 16'h0000;
            end
        end
    endtask

    task automatic test_ldr_write();
        logic e_ce, e_we;
        do_reset();
        ldr_addr = 20'h00100; ldr_wdata = 16'h1234; ldr_be = 2'b11; ldr_we = 1'b1;
        ldr_req = 1'b1;
        for (int k = 1; k <= 5; k++) begin
            tick();
            e_ce = (k <= 3) ? 1'b0 : 1'b1;
            e_we = (k == 2 || k == 3) ? 1'b0 : 1'b1;
            vectors++;
            if (CE_N !== e_ce || OE_N !== 1'b1 || UB_N !== e_ce || LB_N !== e_ce) begin
                miscompares++;
                $display("FAIL ldr_write_strobes cyc %0d got CE%b OE%b UB%b LB%b exp CE%b OE1", k, CE_N, OE_N, UB_N, LB_N, e_ce);
            end
            vectors++;
            if (WE_N !== e_we) begin
                miscompares++;
                $display("FAIL ldr_write_we cyc %0d got %b exp %b", k, WE_N, e_we);
            end
            vectors++;
            if (mem_wdata_oe !== (k <= 4)) begin
                miscompares++;
                $display("FAIL ldr_write_oe cyc %0d got %b exp %b", k, mem_wdata_oe, (k <= 4));
            end
            vectors++;
            if (ldr_ack !== (k == 4) || cpu_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL ldr_write_ack cyc %0d got ldr=%b cpu=%b exp %b/0", k, ldr_ack, cpu_ack, (k == 4));
            end
            if (k <= 4) begin
                vectors++;
                if (mem_wdata !== 16'h1234 || A !== 20'h00100 || grant !== 1'b1) begin
                    miscompares++;
                    $display("FAIL ldr_write_data cyc %0d got wd=%h A=%h g=%b exp 1234/00100/1", k, mem_wdata, A, grant);
                end
            end
            if (k == 4) ldr_req = 1'b0;
        end
    endtask

    task automatic test_byte_lanes();
        do_reset();
        cpu_addr = 20'h00200; cpu_wdata = 16'hAB00; cpu_be = 2'b10; cpu_we = 1'b1;
        cpu_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            if (k <= 3) begin
                vectors++;
                if (UB_N !== 1'b0 || LB_N !== 1'b1) begin
                    miscompares++;
                    $display("FAIL byte_be10 cyc %0d got UB%b LB%b exp UB0 LB1", k, UB_N, LB_N);
                end
            end
            if (k == 4) begin
                vectors++;
                if (cpu_ack !== 1'b1) begin
                    miscompares++;
                    $display("FAIL byte_be10_ack got %b exp 1", cpu_ack);
                end
                cpu_req = 1'b0;
            end
        end
        tick();
        cpu_addr = 20'h00300; cpu_be = 2'b00; cpu_we = 1'b0; mem_rdata = 16'h5A5A;
        cpu_req = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            vectors++;
            if (UB_N !== 1'b1 || LB_N !== 1'b1) begin
                miscompares++;
                $display("FAIL byte_be00 cyc %0d got UB%b LB%b exp UB1 LB1", k, UB_N, LB_N);
            end
            if (k == 4) begin
                vectors++;
                if (cpu_ack !== 1'b1 || rdata !== 16'h5A5A) begin
                    miscompares++;
                    $display("FAIL byte_be00_ack got ack=%b rd=%h exp 1/5A5A", cpu_ack, rdata);
                end
                cpu_req = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_we = 1'b0; ldr_we = 1'b0; cpu_be = 2'b11; ldr_be = 2'b11;
        cpu_addr = 20'h00001; ldr_addr = 20'h00002; mem_rdata = 16'h1111;
        Reset = 1'b1; cpu_req = 1'b1; ldr_req = 1'b1;
        tick();
        Reset = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            tick();
            vectors++;
            if (cpu_ack !== (k == 4 || k == 14)) begin
                miscompares++;
                $display("FAIL tie_cpu_ack cyc %0d got %b exp %b", k, cpu_ack, (k == 4 || k == 14));
            end
            vectors++;
            if (ldr_ack !== (k == 9 || k == 19)) begin
                miscompares++;
                $display("FAIL tie_ldr_ack cyc %0d got %b exp %b", k, ldr_ack, (k == 9 || k == 19));
            end
            if (k == 1 || k == 6 || k == 11 || k == 16) begin
                vectors++;
                if (grant !== (k == 6 || k == 16)) begin
                    miscompares++;
                    $display("FAIL tie_grant cyc %0d got %b exp %b", k, grant, (k == 6 || k == 16));
                end
            end
        end
        cpu_req = 1'b0; ldr_req = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        cpu_addr = 20'h00400; cpu_wdata = 16'hCAFE; cpu_be = 2'b11; cpu_we = 1'b1;
        cpu_req = 1'b1;
        tick();
        tick();
        vectors++;
        if (WE_N !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_access got WE_N=%b exp 0", WE_N);
        end
        Reset = 1'b1; ldr_req = 1'b1;
        tick();
        vectors++;
        if ({CE_N, OE_N, WE_N, UB_N, LB_N} !== 5'b11111 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_strobes got %b busy=%b exp 11111/0", {CE_N, OE_N, WE_N, UB_N, LB_N}, busy);
        end
        vectors++;
        if (cpu_ack !== 1'b0 || ldr_ack !== 1'b0 || mem_wdata_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL rst_mid_ack got cpu=%b ldr=%b oe=%b exp 0/0/0", cpu_ack, ldr_ack, mem_wdata_oe);
        end
        Reset = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            if (k == 1) begin
                vectors++;
                if (grant !== 1'b0 || A !== 20'h00400) begin
                    miscompares++;
                    $display("FAIL rst_mid_tie got g=%b A=%h exp 0/00400", grant, A);
                end
            end
            vectors++;
            if (cpu_ack !== (k == 4) || ldr_ack !== 1'b0) begin
                miscompares++;
                $display("FAIL rst_mid_after cyc %0d got cpu=%b ldr=%b exp %b/0", k, cpu_ack, ldr_ack, (k == 4));
            end
            if (k == 4) begin
                cpu_req = 1'b0; ldr_req = 1'b0;
            end
        end
    endtask

    task automatic test_wait5_latch();
        logic e_lo;
        do_reset();
        cpu_addr = 20'h00ABC; cpu_we = 1'b0; cpu_be = 2'b11; mem_rdata = 16'h7777;
        cpu_req = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 1) begin
                cpu_addr = 20'hFFFFF; cpu_we = 1'b1; cpu_be = 2'b00; cpu_wdata = 16'hDEAD;
            end
            e_lo = (k <= 6) ? 1'b0 : 1'b1;
            vectors++;
            if (a5 !== 20'h00ABC) begin
                miscompares++;
                $display("FAIL w5_addr cyc %0d got %h exp 00ABC", k, a5);
            end
            vectors++;
            if (ce_n5 !== e_lo || oe_n5 !== e_lo || we_n5 !== 1'b1 || lb_n5 !== e_lo) begin
                miscompares++;
                $display("FAIL w5_strobes cyc %0d got CE%b OE%b WE%b LB%b exp CE%b OE%b WE1", k, ce_n5, oe_n5, we_n5, lb_n5, e_lo, e_lo);
            end
            vectors++;
            if (cpu_ack5 !== (k == 7) || ldr_ack5 !== 1'b0) begin
                miscompares++;
                $display("FAIL w5_ack cyc %0d got %b exp %b", k, cpu_ack5, (k == 7));
            end
            if (k == 7) begin
                vectors++;
                if (rdata5 !== 16'h7777) begin
                    miscompares++;
                    $display("FAIL w5_rdata got %h exp 7777", rdata5);
                end
                cpu_req = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_cpu_read();
        test_ldr_write();
        test_byte_lanes();
        test_back_to_back();
        test_reset_mid();
        test_wait5_latch();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
